// File: rtl/memory_if.sv
// rtl/memory_if.sv - Single-port access bundle between a datapath and the unified RAM
//
// Purpose: carries one access per cycle; there is no handshake.
// Ports (signals):
//   R_WBAR  1 = read, 0 = write WDATA at ADDR on the next CLK rising edge
//   ADDR    word address (only the low clog2(DEPTH) bits reach the array)
//   WDATA   write data
//   RDATA   read data returned by the RAM
// Modports: master drives the access, slave is the RAM.
interface memory_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              R_WBAR;
   logic [ADDR_W-1:0] ADDR;
   logic [DATA_W-1:0] WDATA;
   logic [DATA_W-1:0] RDATA;

   modport master (
      output R_WBAR,
      output ADDR,
      output WDATA,
      input  RDATA
   );

   modport slave (
      input  R_WBAR,
      input  ADDR,
      input  WDATA,
      output RDATA
   );
endinterface

// File: rtl/memory.sv
// rtl/memory.sv - Unified instruction/data RAM for the multicycle MIPS datapath
//
// Purpose: word-addressed single-port RAM. Writes happen on the CLK rising
//   edge when R_WBAR=0; RST synchronously clears every word (and wins over
//   a simultaneous write). Addresses wrap modulo DEPTH.
// Ports:
//   CLK        system clock, all state changes on the rising edge
//   RST        synchronous active-high reset
//   bus        memory_if.slave: R_WBAR, ADDR, WDATA in; RDATA out
// Configuration macro: MEMORY_RDATA_REG_EN
//   undefined: RDATA = mem[idx] combinationally (0-cycle latency)
//   defined:   RDATA comes from a register loaded on read cycles (1-cycle
//              latency), held across write cycles, cleared by RST
module memory #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 256
) (
   input logic     CLK,
   input logic     RST,
   memory_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  idx;

   // Upper address bits are deliberately dropped so ADDR aliases modulo DEPTH.
   assign idx = bus.ADDR[IDX_W-1:0];

   generate
      if (ADDR_W > IDX_W) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^bus.ADDR[ADDR_W-1:IDX_W];
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (!bus.R_WBAR) begin
         mem[idx] <= bus.WDATA;
      end
   end

`ifdef MEMORY_RDATA_REG_EN
   logic [DATA_W-1:0] rdata_q;

   // Loads only on read cycles, so a write cycle leaves the last read visible.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rdata_q <= '0;
      end else if (bus.R_WBAR) begin
         rdata_q <= mem[idx];
      end
   end

   assign bus.RDATA = rdata_q;
`else
   // Shows mem[idx] in every cycle, including write cycles (old value until the edge).
   assign bus.RDATA = mem[idx];
`endif

endmodule

// File: tb/tb_memory.sv
// tb/tb_memory.sv - Directed scoreboard bench for memory
module tb_memory;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int DEPTH  = 256;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   logic [DATA_W-1:0] exp_q [$];
   logic [DATA_W-1:0] mdl [DEPTH];

   memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag);
      logic [DATA_W-1:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $error("FAIL %s: scoreboard empty, observed=%h", tag, bus.RDATA);
      end else begin
         e = exp_q.pop_front();
         assert (bus.RDATA === e) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, bus.RDATA, e);
         end
      end
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus.R_WBAR = 1'b0;
      bus.ADDR   = a;
      bus.WDATA  = d;
      @(posedge clk);
      #1;
      bus.R_WBAR = 1'b1;
   endtask

   // Combinational build: sample on the falling edge of the same cycle.
   // Registered build: result appears after the next rising edge.
   task automatic read_check(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e,
                             input string tag);
      bus.R_WBAR = 1'b1;
      bus.ADDR   = a;
      exp_q.push_back(e);
`ifdef MEMORY_RDATA_REG_EN
      @(posedge clk);
      #1;
`else
      @(negedge clk);
`endif
      check(tag);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      n_cmp       = 0;
      n_bad       = 0;
      rst         = 1'b1;
      bus.R_WBAR  = 1'b1;
      bus.ADDR    = '0;
      bus.WDATA   = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      read_check(32'd0,   32'd0, "rst_a0");
      read_check(32'd2,   32'd0, "rst_a2");
      read_check(32'd3,   32'd0, "rst_a3");
      read_check(32'd255, 32'd0, "rst_a255");

      do_write(32'd5, 32'd9);
      read_check(32'd5, 32'd9, "rd5_after_wr");
      read_check(32'd2, 32'd0, "rd2_untouched");
      read_check(32'd3, 32'd0, "rd3_untouched");

      do_write(32'd10, 32'd27);
      read_check(32'd10, 32'd27, "rd10");
      read_check(32'd5,  32'd9,  "rd5_no_corrupt");

      do_write(32'd261, 32'hDEADBEEF);
      read_check(32'd5,   32'hDEADBEEF, "alias_rd5");
      read_check(32'd261, 32'hDEADBEEF, "alias_rd261");
      read_check(32'd10,  32'd27,       "alias_rd10_kept");

`ifndef MEMORY_RDATA_REG_EN
      // Read-during-write: old value before the edge, new value after it.
      bus.R_WBAR = 1'b0;
      bus.ADDR   = 32'd5;
      bus.WDATA  = 32'h0000_1234;
      exp_q.push_back(32'hDEADBEEF);
      @(negedge clk);
      check("rdw_old");
      @(posedge clk);
      #1;
      exp_q.push_back(32'h0000_1234);
      check("rdw_new");
      bus.R_WBAR = 1'b1;
      @(posedge clk);
      #1;
`else
      read_check(32'd5, 32'hDEADBEEF, "reg_rd5");
      do_write(32'd6, 32'd3);
      exp_q.push_back(32'hDEADBEEF);
      check("reg_hold_over_wr");
      do_write(32'd5, 32'h0000_1234);
      read_check(32'd5, 32'h0000_1234, "reg_rd5_new");
      read_check(32'd6, 32'd3,         "reg_rd6");
`endif

      // Scattered writes checked against a bench-side model.
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
      for (int i = 0; i < 6; i++) begin
         a = 32'(20 + i * 37);
         d = $urandom;
         mdl[a[7:0]] = d;
         do_write(a, d);
      end
      for (int i = 0; i < 6; i++) begin
         a = 32'(20 + i * 37);
         read_check(a, mdl[a[7:0]], $sformatf("fill_%0d", i));
      end

      // Reset priority over a simultaneous write.
      rst        = 1'b1;
      bus.R_WBAR = 1'b0;
      bus.ADDR   = 32'd7;
      bus.WDATA  = 32'd1;
      @(posedge clk);
      #1;
      rst        = 1'b0;
      bus.R_WBAR = 1'b1;
      read_check(32'd7,  32'd0, "rstpri_rd7");
      read_check(32'd10, 32'd0, "rstpri_rd10");
      read_check(32'd20, 32'd0, "rstpri_rd20");

      do_write(32'd7, 32'h5A5A_A5A5);
      read_check(32'd7, 32'h5A5A_A5A5, "post_rst_wr7");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
